// File: rtl/id_operand_hazard_unit_if.sv
// Bus bundle for the decode-stage front end (IF->ID, regfile, bypass, ID outputs).
// Flow control: if_valid marks a real instruction on if_pc. There is no ready
// signal. The stall bus replaces it: stall[1]=0 lets ID accept the IF slot on the
// rising edge. stall[1]=1 with stall[2]=1 holds the ID contents. stall[1]=1 with
// stall[2]=0 loads a bubble. stallreq is ID's request for the stall controller to
// hold IF/ID for one cycle.
interface id_operand_hazard_unit_if #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int NUM_FWD = 3,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0]        stall;
    logic                      if_valid;
    logic [PC_W-1:0]           if_pc;
    logic [31:0]               inst_sram_rdata;
    logic [4:0]                rf_raddr1;
    logic [4:0]                rf_raddr2;
    logic [DATA_W-1:0]         rf_rdata1;
    logic [DATA_W-1:0]         rf_rdata2;
    logic [NUM_FWD-1:0]        fwd_we;
    logic [NUM_FWD*5-1:0]      fwd_waddr;
    logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
    logic                      ex_is_load;
    logic                      id_valid;
    logic [PC_W-1:0]           id_pc;
    logic [31:0]               id_inst;
    logic [DATA_W-1:0]         op1;
    logic [DATA_W-1:0]         op2;
    logic                      stallreq;
    logic                      br_e;
    logic [PC_W-1:0]           br_addr;
    logic [31:0]               perf_stall_cnt;

    modport master (
        output stall, if_valid, if_pc, inst_sram_rdata, rf_rdata1, rf_rdata2,
               fwd_we, fwd_waddr, fwd_wdata, ex_is_load,
        input  rf_raddr1, rf_raddr2, id_valid, id_pc, id_inst, op1, op2,
               stallreq, br_e, br_addr, perf_stall_cnt
    );

    modport slave (
        input  stall, if_valid, if_pc, inst_sram_rdata, rf_rdata1, rf_rdata2,
               fwd_we, fwd_waddr, fwd_wdata, ex_is_load,
        output rf_raddr1, rf_raddr2, id_valid, id_pc, id_inst, op1, op2,
               stallreq, br_e, br_addr, perf_stall_cnt
    );
endinterface

// File: rtl/id_operand_hazard_unit.sv
// Decode-stage front end for the 5-stage MIPS pipeline. It holds the IF->ID register
// and replays the SRAM instruction word while ID is held. It also does N-source operand
// bypassing, load-use detection and branch/jump resolution in ID.
// Optional feature macro: ID_PERF_CNT_EN adds a saturating load-use stall counter.
// Without the macro, perf_stall_cnt is tied to zero.
module id_operand_hazard_unit #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int NUM_FWD = 3,
    parameter int STALL_W = 6
) (
    input logic                    clk,
    input logic                    rst,
    id_operand_hazard_unit_if.slave bus
);
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08, FN_JALR = 6'h09;
    localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1, RT_BLTZAL = 5'd16, RT_BGEZAL = 5'd17;

    logic              valid_r;
    logic [PC_W-1:0]   pc_r;
    logic              hold_vld;
    logic [31:0]       inst_hold;
    logic              id_hold, ex_hold, bubble;
    logic [31:0]       inst;
    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt;
    logic [DATA_W-1:0] op1_fwd, op2_fwd;
    logic              uses_rs, uses_rt, is_branch, is_jump, is_jreg, cond;
    logic [4:0]        ex_dst;
    logic              stallreq_w;
    logic [PC_W-1:0]   pc4, br_target, j_target;
    logic              unused_stall;

    assign id_hold = bus.stall[1];
    assign ex_hold = bus.stall[2];
    assign bubble  = id_hold & ~ex_hold;
    assign unused_stall = ^{bus.stall[STALL_W-1:3], bus.stall[0]};

    // IF->ID register: a bubble beats a load, and a load beats a hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
        end else if (bubble) begin
            valid_r <= 1'b0;
        end else if (!id_hold) begin
            valid_r <= bus.if_valid;
            pc_r    <= bus.if_pc;
        end
    end

    // Replay buffer: capture the SRAM word on the first held cycle, because the SRAM
    // output moves on while ID is frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld  <= 1'b0;
            inst_hold <= '0;
        end else if (!id_hold || bubble) begin
            hold_vld  <= 1'b0;
        end else if (!hold_vld) begin
            hold_vld  <= 1'b1;
            inst_hold <= bus.inst_sram_rdata;
        end
    end

    assign inst   = valid_r ? (hold_vld ? inst_hold : bus.inst_sram_rdata) : 32'h0;
    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign funct  = inst[5:0];

    // Bypass network: scan from oldest to youngest so that the lowest index wins
    always_comb begin
        op1_fwd = bus.rf_rdata1;
        op2_fwd = bus.rf_rdata2;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (bus.fwd_we[i] && bus.fwd_waddr[5*i +: 5] == rs)
                op1_fwd = bus.fwd_wdata[DATA_W*i +: DATA_W];
            if (bus.fwd_we[i] && bus.fwd_waddr[5*i +: 5] == rt)
                op2_fwd = bus.fwd_wdata[DATA_W*i +: DATA_W];
        end
        if (rs == 5'd0) op1_fwd = '0;
        if (rt == 5'd0) op2_fwd = '0;
    end

    // Decode register usage and branch/jump class, and evaluate the branch condition
    always_comb begin
        uses_rs   = 1'b1;
        uses_rt   = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_jreg   = 1'b0;
        cond      = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                uses_rt = 1'b1;
                if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) uses_rs = 1'b0;
                if (funct == FN_JR || funct == FN_JALR) is_jreg = 1'b1;
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BLTZAL) begin
                    is_branch = 1'b1;
                    cond      = op1_fwd[DATA_W-1];
                end else if (rt == RT_BGEZ || rt == RT_BGEZAL) begin
                    is_branch = 1'b1;
                    cond      = ~op1_fwd[DATA_W-1];
                end
            end
            OP_J, OP_JAL: begin
                uses_rs = 1'b0;
                is_jump = 1'b1;
            end
            OP_BEQ: begin
                uses_rt   = 1'b1;
                is_branch = 1'b1;
                cond      = (op1_fwd == op2_fwd);
            end
            OP_BNE: begin
                uses_rt   = 1'b1;
                is_branch = 1'b1;
                cond      = (op1_fwd != op2_fwd);
            end
            OP_BLEZ: begin
                is_branch = 1'b1;
                cond      = op1_fwd[DATA_W-1] | (op1_fwd == '0);
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                cond      = ~op1_fwd[DATA_W-1] & (op1_fwd != '0);
            end
            OP_LUI:              uses_rs = 1'b0;
            OP_SB, OP_SH, OP_SW: uses_rt = 1'b1;
            default: ;
        endcase
    end

    // A load in EX has no data yet, so any ID read of its destination must wait a cycle
    assign ex_dst     = bus.fwd_waddr[4:0];
    assign stallreq_w = valid_r & bus.ex_is_load & bus.fwd_we[0] & (ex_dst != 5'd0) &
                        ((uses_rs & (rs == ex_dst)) | (uses_rt & (rt == ex_dst)));

    assign pc4       = pc_r + PC_W'(4);
    assign br_target = pc4 + {{(PC_W-18){inst[15]}}, inst[15:0], 2'b00};
    assign j_target  = {pc4[PC_W-1:28], inst[25:0], 2'b00};

    // Target select; zero when ID holds no control-transfer instruction
    always_comb begin
        bus.br_addr = '0;
        if (is_branch)    bus.br_addr = br_target;
        else if (is_jump) bus.br_addr = j_target;
        else if (is_jreg) bus.br_addr = PC_W'(op1_fwd);
    end

    assign bus.br_e      = valid_r & ~stallreq_w & (is_jump | is_jreg | (is_branch & cond));
    assign bus.stallreq  = stallreq_w;
    assign bus.id_valid  = valid_r;
    assign bus.id_pc     = pc_r;
    assign bus.id_inst   = inst;
    assign bus.rf_raddr1 = rs;
    assign bus.rf_raddr2 = rt;
    assign bus.op1       = op1_fwd;
    assign bus.op2       = op2_fwd;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt;

    // Count load-use stall cycles, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stallreq_w && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.perf_stall_cnt = stall_cnt;
`else
    assign bus.perf_stall_cnt = 32'b0;
`endif
endmodule

// File: tb/tb_id_operand_hazard_unit.sv
// Bench for id_operand_hazard_unit: directed scenarios followed by randomized traffic.
// Every cycle is checked against a behavioural model of the decode stage.
module tb_id_operand_hazard_unit;
    localparam int DATA_W = 32, PC_W = 32, NUM_FWD = 3, STALL_W = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_operand_hazard_unit_if #(.DATA_W(DATA_W), .PC_W(PC_W), .NUM_FWD(NUM_FWD), .STALL_W(STALL_W)) bus ();

    id_operand_hazard_unit #(.DATA_W(DATA_W), .PC_W(PC_W), .NUM_FWD(NUM_FWD), .STALL_W(STALL_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Register file contents seen through the DUT's read addresses
    logic [31:0] regs [32];
    assign bus.rf_rdata1 = regs[bus.rf_raddr1];
    assign bus.rf_rdata2 = regs[bus.rf_raddr2];

    // ---------------- stimulus state ----------------
    logic [5:0]  s_stall;
    logic        s_if_valid;
    logic [31:0] s_if_pc;
    logic [31:0] s_sram;
    logic        s_load;
    logic        f_we   [NUM_FWD];
    logic [4:0]  f_addr [NUM_FWD];
    logic [31:0] f_data [NUM_FWD];

    // ---------------- reference model state ----------------
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_frozen;
    logic [31:0] m_word;
    logic [31:0] m_cnt;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] br_addr;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        stallreq;
        logic        br_e;
    } ref_t;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom();
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 13))
            0, 1: begin
                w[31:26] = 6'h00;
                case ($urandom_range(0, 7))
                    0: w[5:0] = 6'h00;
                    1: w[5:0] = 6'h02;
                    2: w[5:0] = 6'h03;
                    3: w[5:0] = 6'h08;
                    4: w[5:0] = 6'h09;
                    5: w[5:0] = 6'h21;
                    6: w[5:0] = 6'h23;
                    default: w[5:0] = 6'h2A;
                endcase
            end
            2: begin
                w[31:26] = 6'h01;
                case ($urandom_range(0, 4))
                    0: w[20:16] = 5'd0;
                    1: w[20:16] = 5'd1;
                    2: w[20:16] = 5'd16;
                    3: w[20:16] = 5'd17;
                    default: w[20:16] = 5'd3;
                endcase
            end
            3:  w[31:26] = 6'h02;
            4:  w[31:26] = 6'h03;
            5:  w[31:26] = 6'h04;
            6:  w[31:26] = 6'h05;
            7:  w[31:26] = 6'h06;
            8:  w[31:26] = 6'h07;
            9:  w[31:26] = 6'h0F;
            10: w[31:26] = 6'h2B;
            11: w[31:26] = 6'h28;
            12: w[31:26] = 6'h29;
            default: w[31:26] = 6'h23;
        endcase
        return w;
    endfunction

    // Value ID should see for register r: zero register, else youngest bypass hit, else regfile
    function automatic logic [31:0] fwd_value(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        for (int i = 0; i < NUM_FWD; i++)
            if (f_we[i] && f_addr[i] == r) return f_data[i];
        return regs[r];
    endfunction

    // Expected combinational outputs from the instruction the model holds in ID
    function automatic ref_t ref_eval();
        ref_t r;
        logic [31:0] w, a, b, pc4, off;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt;
        logic shift, jreg, jump, branch, reads_rs, reads_rt, taken;
        w  = m_valid ? (m_frozen ? m_word : s_sram) : 32'h0;
        op = w[31:26];
        rs = w[25:21];
        rt = w[20:16];
        fn = w[5:0];
        a  = fwd_value(rs);
        b  = fwd_value(rt);
        shift    = (op == 6'h00) && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
        jreg     = (op == 6'h00) && (fn == 6'h08 || fn == 6'h09);
        jump     = (op == 6'h02) || (op == 6'h03);
        branch   = (op >= 6'h04 && op <= 6'h07) ||
                   (op == 6'h01 && (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17));
        reads_rs = !(jump || op == 6'h0F || shift);
        reads_rt = op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h28 || op == 6'h29 || op == 6'h2B;
        case (op)
            6'h04:   taken = (a == b);
            6'h05:   taken = (a != b);
            6'h06:   taken = ($signed(a) <= 0);
            6'h07:   taken = ($signed(a) > 0);
            6'h01:   taken = (rt == 5'd1 || rt == 5'd17) ? ($signed(a) >= 0) : ($signed(a) < 0);
            default: taken = 1'b0;
        endcase
        pc4 = m_pc + 32'd4;
        off = {{14{w[15]}}, w[15:0], 2'b00};
        if (branch)    r.br_addr = pc4 + off;
        else if (jump) r.br_addr = {pc4[31:28], w[25:0], 2'b00};
        else if (jreg) r.br_addr = a;
        else           r.br_addr = 32'h0;
        r.stallreq = m_valid && s_load && f_we[0] && f_addr[0] != 5'd0 &&
                     ((reads_rs && rs == f_addr[0]) || (reads_rt && rt == f_addr[0]));
        r.br_e = m_valid && !r.stallreq && ((branch && taken) || jump || jreg);
        r.inst = w;
        r.op1  = a;
        r.op2  = b;
        r.ra1  = rs;
        r.ra2  = rt;
        return r;
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_pc     = 32'h0;
        m_frozen = 1'b0;
        m_word   = 32'h0;
        m_cnt    = 32'h0;
    endtask

    // What the clock edge does to the ID slot under the current stall bus
    task automatic model_edge();
        ref_t r;
        r = ref_eval();
        if (r.stallreq && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (s_stall[1] && !s_stall[2]) begin
            m_valid  = 1'b0;
            m_frozen = 1'b0;
        end else if (!s_stall[1]) begin
            m_valid  = s_if_valid;
            m_pc     = s_if_pc;
            m_frozen = 1'b0;
        end else if (!m_frozen) begin
            m_frozen = 1'b1;
            m_word   = s_sram;
        end
    endtask

    task automatic check_model();
        ref_t r;
        logic [31:0] exp_cnt;
        r = ref_eval();
`ifdef ID_PERF_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 32'h0;
`endif
        check("id_valid", 32'(bus.id_valid), 32'(m_valid));
        check("id_pc", bus.id_pc, m_pc);
        check("id_inst", bus.id_inst, r.inst);
        check("rf_raddr1", 32'(bus.rf_raddr1), 32'(r.ra1));
        check("rf_raddr2", 32'(bus.rf_raddr2), 32'(r.ra2));
        check("op1", bus.op1, r.op1);
        check("op2", bus.op2, r.op2);
        check("stallreq", 32'(bus.stallreq), 32'(r.stallreq));
        check("br_e", 32'(bus.br_e), 32'(r.br_e));
        check("br_addr", bus.br_addr, r.br_addr);
        check("perf_stall_cnt", bus.perf_stall_cnt, exp_cnt);
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply();
        bus.stall           = s_stall;
        bus.if_valid        = s_if_valid;
        bus.if_pc           = s_if_pc;
        bus.inst_sram_rdata = s_sram;
        bus.ex_is_load      = s_load;
        for (int i = 0; i < NUM_FWD; i++) begin
            bus.fwd_we[i]              = f_we[i];
            bus.fwd_waddr[5*i +: 5]    = f_addr[i];
            bus.fwd_wdata[32*i +: 32]  = f_data[i];
        end
    endtask

    task automatic to_negedge();
        apply();
        @(negedge clk);
        check_model();
    endtask

    task automatic to_next();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        for (int i = 0; i < NUM_FWD; i++) begin
            f_we[i]   = 1'b0;
            f_addr[i] = 5'd0;
            f_data[i] = 32'h0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_id_valid"}, 32'(bus.id_valid), 32'h0);
        check({tag, "_id_pc"}, bus.id_pc, 32'h0);
        check({tag, "_id_inst"}, bus.id_inst, 32'h0);
        check({tag, "_raddr1"}, 32'(bus.rf_raddr1), 32'h0);
        check({tag, "_raddr2"}, 32'(bus.rf_raddr2), 32'h0);
        check({tag, "_op1"}, bus.op1, 32'h0);
        check({tag, "_op2"}, bus.op2, 32'h0);
        check({tag, "_stallreq"}, 32'(bus.stallreq), 32'h0);
        check({tag, "_br_e"}, 32'(bus.br_e), 32'h0);
        check({tag, "_br_addr"}, bus.br_addr, 32'h0);
        check({tag, "_perf"}, bus.perf_stall_cnt, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] exp_perf;
        for (int i = 0; i < 32; i++) regs[i] = rand_val();
        regs[1] = 32'h1;
        regs[2] = 32'h2;
        regs[9] = 32'h0000_5A5A;
        s_stall = '0; s_if_valid = 1'b0; s_if_pc = '0; s_sram = '0; s_load = 1'b0;
        clear_fwd();
        model_reset();
        rst = 1'b1;
        apply();
        #2;
        check_all_zero("reset_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Bypass priority: EX beats MEM beats WB, and $0 reads as zero
        s_stall = 6'b000000; s_if_valid = 1'b1; s_if_pc = 32'h100;
        to_negedge(); to_next();
        s_sram = 32'h00A0_1821;
        for (int i = 0; i < NUM_FWD; i++) begin f_we[i] = 1'b1; f_addr[i] = 5'd5; end
        f_data[0] = 32'hAAAA_0001; f_data[1] = 32'hBBBB_0002; f_data[2] = 32'hCCCC_0003;
        s_stall = 6'b000110; s_if_pc = 32'h200;
        to_negedge();
        check("prio_op1_ex", bus.op1, 32'hAAAA_0001);
        check("prio_op2_zero", bus.op2, 32'h0);
        to_next();
        f_we[0] = 1'b0; s_sram = $urandom(); s_stall = 6'b000000;
        to_negedge();
        check("prio_op1_mem", bus.op1, 32'hBBBB_0002);
        to_next();

        // Load-use on beq $8,$9, then the load data arrives through MEM
        s_sram = 32'h1109_0004; s_load = 1'b1;
        clear_fwd(); f_we[0] = 1'b1; f_addr[0] = 5'd8;
        s_stall = 6'b000111; s_if_pc = 32'h300;
        to_negedge();
        check("lu_stallreq_on", 32'(bus.stallreq), 32'h1);
        check("lu_br_e_blocked", 32'(bus.br_e), 32'h0);
        to_next();
        s_sram = $urandom(); s_load = 1'b0;
        clear_fwd(); f_we[1] = 1'b1; f_addr[1] = 5'd8; f_data[1] = regs[9];
        s_stall = 6'b000000; s_if_pc = 32'h0040_0000;
        to_negedge();
        check("lu_stallreq_off", 32'(bus.stallreq), 32'h0);
        check("lu_br_e", 32'(bus.br_e), 32'h1);
        check("lu_br_addr", bus.br_addr, 32'h0000_0214);
        to_next();

        // bne backwards by one word, held for a second cycle
        s_sram = 32'h1422_FFFF; clear_fwd(); s_stall = 6'b000110;
        to_negedge();
        check("bne_br_e", 32'(bus.br_e), 32'h1);
        check("bne_br_addr", bus.br_addr, 32'h0040_0000);
        to_next();
        s_sram = $urandom();
        to_negedge();
        check("bne_held_br_e", 32'(bus.br_e), 32'h1);
        check("bne_held_br_addr", bus.br_addr, 32'h0040_0000);
        to_next();
        s_stall = 6'b000000; s_if_pc = 32'h0040_0100;
        to_negedge(); to_next();
        s_sram = 32'h03E0_0008; f_we[0] = 1'b1; f_addr[0] = 5'd31; f_data[0] = 32'h1234_5678;
        s_if_valid = 1'b0;
        to_negedge();
        check("jr_br_e", 32'(bus.br_e), 32'h1);
        check("jr_br_addr", bus.br_addr, 32'h1234_5678);
        to_next();

        // Replay: ID frozen for three cycles while the SRAM output wanders
        clear_fwd(); s_if_valid = 1'b1; s_if_pc = 32'h300; s_sram = $urandom();
        to_negedge(); to_next();
        s_sram = 32'h0109_1821; s_stall = 6'b000111;
        exp_q.push_back(32'h0109_1821);
        for (int k = 0; k < 3; k++) begin
            to_negedge();
            check("replay_hold", bus.id_inst, exp_q[0]);
            to_next();
            s_sram = $urandom();
        end
        s_stall = 6'b000000; s_if_pc = 32'h304;
        to_negedge();
        check("replay_release", bus.id_inst, exp_q.pop_front());
        to_next();
        s_sram = 32'h0022_1821;
        to_negedge();
        check("replay_new_word", bus.id_inst, 32'h0022_1821);
        check("replay_new_pc", bus.id_pc, 32'h304);
        to_next();

        // Asynchronous reset in the middle of a held jump
        s_if_pc = 32'h0040_0010; s_sram = $urandom();
        to_negedge(); to_next();
        s_sram = 32'h0800_0040; s_stall = 6'b000111;
        to_negedge();
        check("pre_reset_br_e", 32'(bus.br_e), 32'h1);
        check("pre_reset_br_addr", bus.br_addr, 32'h0000_0100);
        to_next();
        s_sram = $urandom();
        apply();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stall counter: five consecutive load-use cycles
        s_stall = 6'b000000; s_if_valid = 1'b1; s_if_pc = 32'h500; s_sram = $urandom();
        clear_fwd(); s_load = 1'b0;
        to_negedge(); to_next();
        s_sram = 32'h0109_1821; s_load = 1'b1; f_we[0] = 1'b1; f_addr[0] = 5'd9;
        s_stall = 6'b000111;
        repeat (5) begin to_negedge(); to_next(); end
        s_load = 1'b0; f_we[0] = 1'b0;
        to_negedge();
`ifdef ID_PERF_CNT_EN
        exp_perf = 32'd5;
`else
        exp_perf = 32'd0;
`endif
        check("perf_five", bus.perf_stall_cnt, exp_perf);
        to_next();

        // Randomized traffic
        repeat (400) begin
            logic [1:0] core;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: core = 2'b00;
                6:                core = 2'b01;
                default:          core = 2'b11;
            endcase
            s_stall    = {3'($urandom_range(0, 7)), core, 1'($urandom_range(0, 1))};
            s_if_valid = ($urandom_range(0, 4) != 0);
            s_if_pc    = $urandom();
            s_if_pc[1:0] = 2'b00;
            s_sram     = rand_inst();
            s_load     = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NUM_FWD; i++) begin
                f_we[i]   = 1'($urandom_range(0, 1));
                f_addr[i] = 5'($urandom_range(0, 7));
                f_data[i] = rand_val();
            end
            to_negedge();
            to_next();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
